rv_control_mc: RTL and testbench
================================

RV_CONTROL_MC -- requirements
Module: rv_control_mc

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum cycles to wait for an instr/data memory ack; 0 disables the timeout.
REQ-002 SHALL have parameter EN_ENV, default 1, meaning SYSTEM opcode traps when 1 and is illegal when 0.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 instr_op_i  in  7  opcode from instruction register, valid from DECODE onward.
REQ-006 imem_ack_i  in  1  instruction memory ack; dmem_ack_i  in  1  data memory ack.
REQ-007 branch_taken_i  in  1  branch compare result, sampled in EXEC.
REQ-008 imem_req_o  out  1  fetch request; IRWrite_o  out  1  instruction register load.
REQ-009 dmem_req_o, MemRead_o, MemWrite_o  out  1 each  data memory request and direction.
REQ-010 MemtoReg_o  out  2  writeback source: 0 ALU, 1 data memory, 2 PC+4.
REQ-011 ALUOp_o  out  3  ALU op class: 0 load/store, 1 branch, 2 R/I, 3 JAL/JALR, 4 LUI, 5 AUIPC.
REQ-012 ALUSrc_o, RegWrite_o, PCWrite_o  out  1 each; PCSel_o  out  2  next PC: 0 PC+4, 1 branch/JAL target, 2 JALR target.
REQ-013 trap_o  out  1; trap_cause_o  out  2  causes: 0 illegal, 1 env, 2 imem timeout, 3 dmem timeout.

Function
REQ-014 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-015 Opcodes SHALL decode as: R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
REQ-016 FETCH: imem_req_o SHALL be held high until imem_ack_i; on the ack cycle IRWrite_o=1 and the next state is DECODE.
REQ-017 DECODE: the opcode class SHALL be latched; the state lasts 1 cycle and goes to TRAP (cause 0) on an unknown opcode or SYSTEM with EN_ENV=0, to TRAP (cause 1) on SYSTEM with EN_ENV=1, else to EXEC.
REQ-018 EXEC: the state lasts 1 cycle; ALUOp_o follows REQ-011, and ALUSrc_o=1 for I, LOAD, S and JALR.
REQ-019 EXEC branch: PCWrite_o=1 and PCSel_o=branch_taken_i?1:0, then FETCH; LOAD/S go to MEM; all others go to WB.
REQ-020 MEM: dmem_req_o SHALL be held high, with MemRead_o (LOAD) or MemWrite_o (S), until dmem_ack_i.
REQ-021 MEM on ack: S asserts PCWrite_o with PCSel_o=0 and goes to FETCH; LOAD goes to WB.
REQ-022 WB: the state lasts 1 cycle with RegWrite_o=1 and PCWrite_o=1.
REQ-023 WB: MemtoReg_o=1 for LOAD, 2 for JAL/JALR, else 0; PCSel_o=1 for JAL, 2 for JALR, else 0; next state FETCH.
REQ-024 PCWrite_o SHALL pulse exactly once per retired instruction; RegWrite_o SHALL never assert outside WB.
REQ-025 Each wait counter SHALL clear on entry to FETCH or MEM and increment each un-acked cycle.
REQ-026 On count==MEM_TIMEOUT with no ack and MEM_TIMEOUT>0, the FSM SHALL go to TRAP with cause 2 (FETCH) or 3 (MEM).
REQ-027 An ack in the same cycle the count reaches MEM_TIMEOUT SHALL take priority over the timeout.
REQ-028 TRAP: trap_o=1 and trap_cause_o SHALL be held, all other outputs 0; TRAP is left only by reset.
REQ-029 Latency SHALL be, with zero-wait memories: branch 3 cycles, R/I/LUI/AUIPC/JAL/JALR 4, store 4, load 5.

Reset
REQ-030 While rst_ni=0 all outputs SHALL be 0 (imem_req_o gated), state=FETCH, counters and class register cleared.
REQ-031 Reset asserted mid-instruction SHALL abort it immediately, with no PCWrite_o/RegWrite_o pulse.
REQ-032 The first imem_req_o SHALL occur in the first cycle after rst_ni rises.

Structure
REQ-033 Package rv_pkg SHALL hold the opcode constants, the state enum, the ALUOp enum, the MemtoReg/PCSel encodings and the trap cause enum.
REQ-034 Sub-module rv_opdec (combinational opcode to class plus static ALUOp/ALUSrc) SHALL be instantiated once; the FSM and counters stay in rv_control_mc.

Verification
REQ-035 R-type 0110011, zero-wait memories -> IRWrite_o at cycle 1, ALUOp_o=2 in EXEC, RegWrite_o/PCWrite_o in cycle 4, PCSel_o=0.
REQ-036 LOAD 0000011 with dmem_ack_i delayed 3 cycles -> dmem_req_o/MemRead_o held 4 cycles, then WB with MemtoReg_o=1.
REQ-037 B 1100011 with branch_taken_i=1 then 0 -> PCSel_o=1 then 0, RegWrite_o never asserted.
REQ-038 MEM_TIMEOUT=15, imem_ack_i held 0 -> trap_o=1, trap_cause_o=2 after 16 FETCH cycles; ack at count 15 -> no trap.
REQ-039 Opcode 1111111 -> TRAP cause 0; SYSTEM with EN_ENV=1 -> cause 1; rst_ni pulsed in MEM -> outputs 0, restart in FETCH.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared opcodes, state/class/ALU enums and control encodings for
//            the multi-cycle RV control unit.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } opcls_e;

    typedef enum logic [2:0] {
        ALU_LS    = 3'd0,
        ALU_BR    = 3'd1,
        ALU_RI    = 3'd2,
        ALU_JMP   = 3'd3,
        ALU_LUI   = 3'd4,
        ALU_AUIPC = 3'd5
    } aluop_e;

    typedef enum logic [1:0] {
        TC_ILLEGAL = 2'd0,
        TC_ENV     = 2'd1,
        TC_IMEM    = 2'd2,
        TC_DMEM    = 2'd3
    } trap_cause_e;

    localparam logic [1:0] c_MTR_ALU  = 2'd0;
    localparam logic [1:0] c_MTR_MEM  = 2'd1;
    localparam logic [1:0] c_MTR_PC4  = 2'd2;

    localparam logic [1:0] c_PCS_PC4  = 2'd0;
    localparam logic [1:0] c_PCS_TGT  = 2'd1;
    localparam logic [1:0] c_PCS_JALR = 2'd2;

    typedef struct packed {
        logic        imem_req;
        logic        irwrite;
        logic        dmem_req;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_to_reg;
        aluop_e      aluop;
        logic        alu_src;
        logic        reg_write;
        logic        pc_write;
        logic [1:0]  pc_sel;
        logic        trap;
        trap_cause_e trap_cause;
    } ctrl_t;

    function automatic logic [1:0] wb_mem_to_reg(input opcls_e cls);
        case (cls)
            CLS_LOAD:          return c_MTR_MEM;
            CLS_JAL, CLS_JALR: return c_MTR_PC4;
            default:           return c_MTR_ALU;
        endcase
    endfunction

    function automatic logic [1:0] wb_pc_sel(input opcls_e cls);
        case (cls)
            CLS_JAL:  return c_PCS_TGT;
            CLS_JALR: return c_PCS_JALR;
            default:  return c_PCS_PC4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_opdec.sv
`default_nettype none
// ============================================================================
// Module   : rv_opdec
// Brief    : Combinational opcode decoder: opcode class plus static ALUOp and
//            ALU operand-B select.
// Revision : 1.0 - initial release
// ============================================================================
module rv_opdec
    import rv_pkg::*;
(
    input  logic [6:0] i_op,
    output opcls_e     o_cls,
    output aluop_e     o_aluop,
    output logic       o_alusrc
);

    always_comb begin
        o_cls    = CLS_ILLEGAL;
        o_aluop  = ALU_LS;
        o_alusrc = 1'b0;
        case (i_op)
            c_OP_R: begin
                o_cls   = CLS_R;
                o_aluop = ALU_RI;
            end
            c_OP_I: begin
                o_cls    = CLS_I;
                o_aluop  = ALU_RI;
                o_alusrc = 1'b1;
            end
            c_OP_LOAD: begin
                o_cls    = CLS_LOAD;
                o_alusrc = 1'b1;
            end
            c_OP_STORE: begin
                o_cls    = CLS_STORE;
                o_alusrc = 1'b1;
            end
            c_OP_BRANCH: begin
                o_cls   = CLS_BRANCH;
                o_aluop = ALU_BR;
            end
            c_OP_JAL: begin
                o_cls   = CLS_JAL;
                o_aluop = ALU_JMP;
            end
            c_OP_JALR: begin
                o_cls    = CLS_JALR;
                o_aluop  = ALU_JMP;
                o_alusrc = 1'b1;
            end
            c_OP_LUI: begin
                o_cls   = CLS_LUI;
                o_aluop = ALU_LUI;
            end
            c_OP_AUIPC: begin
                o_cls   = CLS_AUIPC;
                o_aluop = ALU_AUIPC;
            end
            c_OP_SYSTEM: o_cls = CLS_SYSTEM;
            default:     o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : rv_control_mc
// Brief    : Multi-cycle RV control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with
//            memory-ack timeout supervision.
// Revision : 1.0 - initial release
// ============================================================================
module rv_control_mc
    import rv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int EN_ENV      = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] instr_op_i,
    input  logic       imem_ack_i,
    input  logic       dmem_ack_i,
    input  logic       branch_taken_i,
    output logic       imem_req_o,
    output logic       IRWrite_o,
    output logic       dmem_req_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic [1:0] MemtoReg_o,
    output logic [2:0] ALUOp_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       PCWrite_o,
    output logic [1:0] PCSel_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o
);

    localparam int             CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_e            r_state;
    state_e            w_state_nxt;
    trap_cause_e       r_cause;
    trap_cause_e       w_cause_nxt;
    opcls_e            r_cls;
    aluop_e            r_aluop;
    logic              r_alusrc;
    logic [CNT_W-1:0]  r_cnt;

    opcls_e            w_dec_cls;
    aluop_e            w_dec_aluop;
    logic              w_dec_alusrc;
    logic              w_timeout;
    logic              w_waiting;
    ctrl_t             w_ctrl;
    ctrl_t             w_out;

    rv_opdec u_opdec (
        .i_op     (instr_op_i),
        .o_cls    (w_dec_cls),
        .o_aluop  (w_dec_aluop),
        .o_alusrc (w_dec_alusrc)
    );

    assign w_timeout = (MEM_TIMEOUT > 0) && (r_cnt == c_TIMEOUT);
    assign w_waiting = ((r_state == S_FETCH) && !imem_ack_i) ||
                       ((r_state == S_MEM)   && !dmem_ack_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FETCH;
            r_cause <= TC_ILLEGAL;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Class and static ALU controls are captured once, in DECODE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cls    <= CLS_R;
            r_aluop  <= ALU_LS;
            r_alusrc <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_cls    <= w_dec_cls;
            r_aluop  <= w_dec_aluop;
            r_alusrc <= w_dec_alusrc;
        end
    end

    // Any state change clears the counter, so it starts at 0 on entering FETCH or MEM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_ctrl      = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.imem_req = 1'b1;
                if (imem_ack_i) begin
                    w_ctrl.irwrite = 1'b1;
                    w_state_nxt    = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = TC_IMEM;
                end
            end
            S_DECODE: begin
                if ((w_dec_cls == CLS_ILLEGAL) || ((w_dec_cls == CLS_SYSTEM) && (EN_ENV == 0))) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = TC_ILLEGAL;
                end else if (w_dec_cls == CLS_SYSTEM) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = TC_ENV;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_ctrl.aluop   = r_aluop;
                w_ctrl.alu_src = r_alusrc;
                case (r_cls)
                    CLS_BRANCH: begin
                        w_ctrl.pc_write = 1'b1;
                        w_ctrl.pc_sel   = branch_taken_i ? c_PCS_TGT : c_PCS_PC4;
                        w_state_nxt     = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_state_nxt = S_MEM;
                    default:             w_state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                w_ctrl.dmem_req  = 1'b1;
                w_ctrl.mem_read  = (r_cls == CLS_LOAD);
                w_ctrl.mem_write = (r_cls == CLS_STORE);
                if (dmem_ack_i) begin
                    if (r_cls == CLS_STORE) begin
                        w_ctrl.pc_write = 1'b1;
                        w_ctrl.pc_sel   = c_PCS_PC4;
                        w_state_nxt     = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = TC_DMEM;
                end
            end
            S_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.mem_to_reg = wb_mem_to_reg(r_cls);
                w_ctrl.pc_sel     = wb_pc_sel(r_cls);
                w_state_nxt       = S_FETCH;
            end
            S_TRAP: begin
                w_ctrl.trap       = 1'b1;
                w_ctrl.trap_cause = r_cause;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Reset sits in FETCH, so the request must be masked while rst_ni is low.
    assign w_out = rst_ni ? w_ctrl : '0;

    assign imem_req_o   = w_out.imem_req;
    assign IRWrite_o    = w_out.irwrite;
    assign dmem_req_o   = w_out.dmem_req;
    assign MemRead_o    = w_out.mem_read;
    assign MemWrite_o   = w_out.mem_write;
    assign MemtoReg_o   = w_out.mem_to_reg;
    assign ALUOp_o      = w_out.aluop;
    assign ALUSrc_o     = w_out.alu_src;
    assign RegWrite_o   = w_out.reg_write;
    assign PCWrite_o    = w_out.pc_write;
    assign PCSel_o      = w_out.pc_sel;
    assign trap_o       = w_out.trap;
    assign trap_cause_o = w_out.trap_cause;

endmodule
`default_nettype wire

// File: tb/tb_rv_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_control_mc
// Brief    : Table-driven self-checking bench for rv_control_mc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_control_mc;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [6:0] instr_op_i = 7'b0;
    logic       imem_ack_i = 1'b0;
    logic       dmem_ack_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       imem_req_o, IRWrite_o, dmem_req_o, MemRead_o, MemWrite_o;
    logic [1:0] MemtoReg_o;
    logic [2:0] ALUOp_o;
    logic       ALUSrc_o, RegWrite_o, PCWrite_o;
    logic [1:0] PCSel_o;
    logic       trap_o;
    logic [1:0] trap_cause_o;
    logic [14:0] w_oth;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    rv_control_mc #(.MEM_TIMEOUT(15), .EN_ENV(1)) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_op_i     (instr_op_i),
        .imem_ack_i     (imem_ack_i),
        .dmem_ack_i     (dmem_ack_i),
        .branch_taken_i (branch_taken_i),
        .imem_req_o     (imem_req_o),
        .IRWrite_o      (IRWrite_o),
        .dmem_req_o     (dmem_req_o),
        .MemRead_o      (MemRead_o),
        .MemWrite_o     (MemWrite_o),
        .MemtoReg_o     (MemtoReg_o),
        .ALUOp_o        (ALUOp_o),
        .ALUSrc_o       (ALUSrc_o),
        .RegWrite_o     (RegWrite_o),
        .PCWrite_o      (PCWrite_o),
        .PCSel_o        (PCSel_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o)
    );

    assign w_oth = {imem_req_o, IRWrite_o, dmem_req_o, MemRead_o, MemWrite_o, MemtoReg_o,
                    ALUOp_o, ALUSrc_o, RegWrite_o, PCWrite_o, PCSel_o};

    // iw/dw: ack-wait cycles of instr/data memory (99 = never ack); lat: cycle of retire or trap
    typedef struct {
        logic [6:0] op;
        int iw; int dw; bit bt;
        int lat; int irw; int pcw; int rw; int mtr; int pcs; int aop; int asrc;
        int dreq; int mrd; int mwr; int trp; int cause;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int fcnt, dcnt, lat, irw, pcw, rw, mtr, pcs, aop, asrc, dreq, mrd, mwr, trp, cause;
        string p;
        fcnt = 0; dcnt = 0; lat = 0; irw = 0; pcw = 0; rw = 0; mtr = 0; pcs = 0;
        aop = 0; asrc = 0; dreq = 0; mrd = 0; mwr = 0; trp = 0; cause = 0;
        p = $sformatf("v%0d", idx);
        @(negedge clk_i);
        rst_ni = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        instr_op_i = v.op; branch_taken_i = v.bt;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
            if (cyc > 1) @(negedge clk_i);
            imem_ack_i = 1'b0;
            dmem_ack_i = 1'b0;
            #1;
            imem_ack_i = imem_req_o && (fcnt == v.iw);
            dmem_ack_i = dmem_req_o && (dcnt == v.dw);
            #1;
            if (imem_req_o) fcnt++;
            if (dmem_req_o) dcnt++;
            if (IRWrite_o && irw == 0) irw = cyc;
            if (cyc == v.iw + 3) begin
                aop  = int'(ALUOp_o);
                asrc = int'(ALUSrc_o);
            end
            dreq += int'(dmem_req_o);
            mrd  += int'(MemRead_o);
            mwr  += int'(MemWrite_o);
            rw   += int'(RegWrite_o);
            pcw  += int'(PCWrite_o);
            if (PCWrite_o) begin
                mtr = int'(MemtoReg_o);
                pcs = int'(PCSel_o);
                lat = cyc;
            end
            if (trap_o) begin
                trp   = 1;
                cause = int'(trap_cause_o);
                lat   = cyc;
            end
        end
        chk({p, " latency"},   lat,   v.lat);
        chk({p, " irwrite"},   irw,   v.irw);
        chk({p, " pcwrite"},   pcw,   v.pcw);
        chk({p, " regwrite"},  rw,    v.rw);
        chk({p, " memtoreg"},  mtr,   v.mtr);
        chk({p, " pcsel"},     pcs,   v.pcs);
        chk({p, " aluop"},     aop,   v.aop);
        chk({p, " alusrc"},    asrc,  v.asrc);
        chk({p, " dmem_req"},  dreq,  v.dreq);
        chk({p, " memread"},   mrd,   v.mrd);
        chk({p, " memwrite"},  mwr,   v.mwr);
        chk({p, " trap"},      trp,   v.trp);
        chk({p, " cause"},     cause, v.cause);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int viol;
        //            op          iw  dw  bt  lat irw pcw rw mtr pcs aop asrc dreq mrd mwr trp cause
        vecs[0]  = '{7'b0110011,  0,  0, 0,   4,  1,  1, 1,  0,  0,  2,  0,    0,  0,  0,  0, 0};
        vecs[1]  = '{7'b0010011,  0,  0, 0,   4,  1,  1, 1,  0,  0,  2,  1,    0,  0,  0,  0, 0};
        vecs[2]  = '{7'b0000011,  0,  3, 0,   8,  1,  1, 1,  1,  0,  0,  1,    4,  4,  0,  0, 0};
        vecs[3]  = '{7'b0100011,  1,  0, 0,   5,  2,  1, 0,  0,  0,  0,  1,    1,  0,  1,  0, 0};
        vecs[4]  = '{7'b1100011,  0,  0, 1,   3,  1,  1, 0,  0,  1,  1,  0,    0,  0,  0,  0, 0};
        vecs[5]  = '{7'b1100011,  0,  0, 0,   3,  1,  1, 0,  0,  0,  1,  0,    0,  0,  0,  0, 0};
        vecs[6]  = '{7'b1101111,  0,  0, 0,   4,  1,  1, 1,  2,  1,  3,  0,    0,  0,  0,  0, 0};
        vecs[7]  = '{7'b1100111,  2,  0, 0,   6,  3,  1, 1,  2,  2,  3,  1,    0,  0,  0,  0, 0};
        vecs[8]  = '{7'b0110111,  0,  0, 0,   4,  1,  1, 1,  0,  0,  4,  0,    0,  0,  0,  0, 0};
        vecs[9]  = '{7'b0010111,  0,  0, 0,   4,  1,  1, 1,  0,  0,  5,  0,    0,  0,  0,  0, 0};
        vecs[10] = '{7'b0110011, 15,  0, 0,  19, 16,  1, 1,  0,  0,  2,  0,    0,  0,  0,  0, 0};
        vecs[11] = '{7'b0000011,  0, 15, 0,  20,  1,  1, 1,  1,  0,  0,  1,   16, 16,  0,  0, 0};
        vecs[12] = '{7'b1111111,  0,  0, 0,   3,  1,  0, 0,  0,  0,  0,  0,    0,  0,  0,  1, 0};
        vecs[13] = '{7'b1110011,  0,  0, 0,   3,  1,  0, 0,  0,  0,  0,  0,    0,  0,  0,  1, 1};
        vecs[14] = '{7'b0110011, 99,  0, 0,  17,  0,  0, 0,  0,  0,  0,  0,    0,  0,  0,  1, 2};
        vecs[15] = '{7'b0000011,  0, 99, 0,  20,  1,  0, 0,  0,  0,  0,  1,   16, 16,  0,  1, 3};

        // Outputs stay quiet in reset even with acks and opcode driven.
        rst_ni = 1'b0; imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
        instr_op_i = 7'b0110011; branch_taken_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset outputs", int'({w_oth, trap_o, trap_cause_o}), 0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Reset pulsed while a load waits in MEM.
        @(negedge clk_i);
        rst_ni = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0; instr_op_i = 7'b0000011;
        @(negedge clk_i);
        rst_ni = 1'b1; imem_ack_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("mid-mem req/read", int'({dmem_req_o, MemRead_o}), 3);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid-mem async reset", int'({w_oth, trap_o, trap_cause_o}), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("restart in fetch", int'({imem_req_o, dmem_req_o}), 2);

        // Trap is sticky and silent regardless of further inputs.
        @(negedge clk_i);
        rst_ni = 1'b0; instr_op_i = 7'b1111111; imem_ack_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1; imem_ack_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        viol = 0;
        for (int k = 0; k < 6; k++) begin
            imem_ack_i = 1'b1; dmem_ack_i = 1'b1; branch_taken_i = 1'b1;
            #1;
            if (!(trap_o === 1'b1 && trap_cause_o === 2'd0 && w_oth === 15'd0)) viol++;
            @(negedge clk_i);
        end
        chk("trap hold violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
